// File: rtl/ray_tri_inside_test.sv
// Inside-outside edge test of a plane hit point against a triangle.
// One shared cross/dot datapath evaluates one edge per cycle and exits early on the first failing edge.
module ray_tri_inside_test #(
    parameter int ID_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [ID_W-1:0] tri_id,
    input  logic [95:0]     p_hit,
    input  logic [95:0]     v0,
    input  logic [95:0]     v1,
    input  logic [95:0]     v2,
    input  logic [95:0]     normal,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ID_W-1:0] out_id,
    output logic            hit
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_E0   = 3'd1;
    localparam logic [2:0] S_E1   = 3'd2;
    localparam logic [2:0] S_E2   = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [ID_W-1:0]  id_q, out_id_q;
    logic [95:0]      p_q, v0_q, v1_q, v2_q, n_q;
    logic             hit_q, out_valid_q;

    logic [95:0]        va, vb;
    logic signed [31:0] ax, ay, az, bx, by, bz;
    logic signed [31:0] nx, ny, nz, cx, cy, cz;
    logic signed [65:0] dot;
    logic               edgePass;

    // One component of a x b, full 64-bit product difference scaled back to Q16.16.
    function automatic logic signed [31:0] crossTerm(
        input logic signed [31:0] a1, b1, a2, b2
    );
        logic signed [63:0] full;
        full = 64'(a1) * 64'(b1) - 64'(a2) * 64'(b2);
        return 32'(full >>> 16);
    endfunction

    always_comb begin
        va = v0_q;
        vb = v1_q;
        case (state_q)
            S_E1: begin va = v1_q; vb = v2_q; end
            S_E2: begin va = v2_q; vb = v0_q; end
            default: ;
        endcase
    end

    assign ax = vb[31:0]  - va[31:0];
    assign ay = vb[63:32] - va[63:32];
    assign az = vb[95:64] - va[95:64];
    assign bx = p_q[31:0]  - va[31:0];
    assign by = p_q[63:32] - va[63:32];
    assign bz = p_q[95:64] - va[95:64];
    assign nx = n_q[31:0];
    assign ny = n_q[63:32];
    assign nz = n_q[95:64];

    assign cx = crossTerm(ay, bz, az, by);
    assign cy = crossTerm(az, bx, ax, bz);
    assign cz = crossTerm(ax, by, ay, bx);

    // Dot product kept at full precision so the sign decision is exact; zero counts as inside.
    assign dot = 66'(64'(nx) * 64'(cx)) + 66'(64'(ny) * 64'(cy)) + 66'(64'(nz) * 64'(cz));
    assign edgePass = (dot >= 0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (in_valid) state_d = S_E0;
            S_E0:   state_d = edgePass ? S_E1 : S_DONE;
            S_E1:   state_d = edgePass ? S_E2 : S_DONE;
            S_E2:   state_d = S_DONE;
            S_DONE: if (out_valid_q && out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            id_q        <= '0;
            p_q         <= '0;
            v0_q        <= '0;
            v1_q        <= '0;
            v2_q        <= '0;
            n_q         <= '0;
            hit_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        id_q <= tri_id;
                        p_q  <= p_hit;
                        v0_q <= v0;
                        v1_q <= v1;
                        v2_q <= v2;
                        n_q  <= normal;
                    end
                end
                S_E0, S_E1, S_E2: begin
                    if (!edgePass || state_q == S_E2) hit_q <= edgePass;
                end
                // Result is presented one cycle after the decision and held until taken.
                S_DONE: begin
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                        out_id_q    <= id_q;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign out_id    = out_id_q;
    assign hit       = hit_q;
endmodule
